multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit for the MIPS-subset datapath: register file, ALU and memory file. It fetches an instruction over the memory handshake, decodes opcode/funct, then drives register addresses, ALU select, memory strobes and register write-enable across FETCH/DECODE/EXEC/MEM/WB states. It replaces the ad-hoc in-`always` sequencing in the processor top level, so that each shared resource is used once per state. It also flags illegal instructions and memory timeouts.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter
- MEM_TIMEOUT, 15, max wait cycles for mem_ready before trap (1..255)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  leave IDLE and begin fetching
- instr  in  32  memory read data; captured in FETCH when mem_ready=1
- mem_ready  in  1  memory completes the current request
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (SW), 0 = read
- mem_sel  out  1  address source: 0 = PC, 1 = ALU result
- ir_we  out  1  datapath IR load strobe
- pc_we  out  1  PC += 4 strobe
- rs_addr, rt_addr  out  5 each  register file read addresses
- wr_addr  out  5  register file write address
- reg_we  out  1  register file write enable
- alu_sel  out  3  ALU operation code
- alu_src_imm  out  1  ALU B operand: 0 = rt data, 1 = sign-extended imm16
- wb_src  out  1  write-back source: 0 = ALU, 1 = memory
- busy  out  1  not in IDLE or TRAP
- illegal  out  1  sticky: undecodable instruction
- timeout  out  1  sticky: mem_ready not seen within MEM_TIMEOUT
- retired  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Internal IR is a 32-bit register. Outputs are combinational from state and IR only (Moore). No output depends on instr or mem_ready combinationally, except ir_we and pc_we.
- IDLE: all strobes 0. start=1 -> FETCH.
- FETCH: mem_req=1, mem_sel=0, mem_we=0. On mem_ready: IR<=instr, ir_we=1, pc_we=1 in that same cycle, then -> DECODE.
- DECODE: rs_addr=IR[25:21], rt_addr=IR[20:16]. These stay driven from IR in every state until the next fetch.
  - Legal opcodes: 0 (R-type), 8 (ADDI), 35 (LW), 43 (SW).
  - Legal R-type funct values and alu_sel: 32 ADD 000; 24 MULT 001; 36 AND 010; 37 OR 011; 38 XOR 100; 39 NOR 101; 0 SLL 110; 2 SRL 111.
  - Legal -> EXEC. Anything else -> TRAP with illegal<=1.
- EXEC: alu_sel as decoded. ADDI, LW and SW use alu_sel=000 and alu_src_imm=1. R-type -> WB; ADDI -> WB; LW and SW -> MEM.
- MEM: mem_req=1, mem_sel=1, mem_we=1 only for SW. alu_sel and alu_src_imm are held. On mem_ready: SW -> FETCH with retired+1; LW -> WB.
- WB: reg_we=1 for one cycle. wr_addr=IR[15:11] for R-type, IR[20:16] otherwise. wb_src=1 only for LW. If wr_addr==0, reg_we is forced to 0 but the instruction still retires. retired+1, then -> FETCH.
- Memory wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments on each cycle that mem_req=1 and mem_ready=0.
  - Reaching MEM_TIMEOUT -> TRAP with timeout<=1.
- TRAP: all strobes 0, busy=0. Only reset exits.
- start is ignored outside IDLE. mem_ready is ignored when mem_req=0.

## Timing
- Reset values: state IDLE, IR 0, retired 0, illegal 0, timeout 0, wait counter 0. All outputs 0, including rs_addr/rt_addr/wr_addr.
- Reset asserted in any state, including mid-MEM with mem_req high, takes effect at the next edge. mem_req is 0 in the following cycle.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - R-type and ADDI: 4 cycles (FETCH, DECODE, EXEC, WB).
  - SW: 4 cycles (FETCH, DECODE, EXEC, MEM).
  - LW: 5 cycles.
  - Each memory wait cycle adds 1.
- The first FETCH cycle follows the edge that samples start=1.
- retired increments on the edge leaving WB, or leaving MEM for SW. Wrap from 2^CNT_W-1 goes to 0 with no flag.
- mem_ready high on the same cycle the wait count reaches MEM_TIMEOUT: the access completes and no trap is taken.

## Structure
- Package proc_pkg holds:
  - opcode constants (OP_RTYPE=0, OP_ADDI=8, OP_LW=35, OP_SW=43);
  - funct constants;
  - the 3-bit ALU_SEL codes shared with alu;
  - the state enum.
- Sub-module instr_decoder (combinational) maps IR to: is_legal, is_rtype, is_load, is_store, alu_sel, and a dest-field select. multicycle_ctrl holds the state machine, IR, counters and sticky flags.

## Test plan
- Reset: hold reset 2 cycles mid-run -> every output 0 and state IDLE. After start, mem_req=1 on the next cycle.
- ADD $3,$1,$2 (0x00221820), zero-wait memory:
  - DECODE: rs_addr=1, rt_addr=2.
  - EXEC: alu_sel=000.
  - WB: reg_we=1, wr_addr=3, wb_src=0.
  - retired=1 after 4 cycles.
- ADDI $0,$5,7 (0x20A00007) -> alu_src_imm=1 in EXEC; WB has wr_addr=0 and reg_we=0; retired still increments.
- SW $4,8($6) (0xACC40008), mem_ready delayed 3 cycles -> MEM holds mem_req=1, mem_we=1, mem_sel=1 for 4 cycles; returns to FETCH with no reg_we; total 7 cycles.
- Illegal inputs:
  - opcode 0x3F -> TRAP after DECODE, illegal=1, busy=0; start is ignored.
  - R-type funct 3 -> same result.
- Timeout: mem_ready never asserted in FETCH with MEM_TIMEOUT=15 -> timeout=1 after 15 request cycles and no ir_we. With mem_ready on the 15th cycle instead, the fetch completes normally.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared encodings for the MIPS-subset datapath: opcodes, functs, ALU codes
// and the control FSM state type.
package proc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_MULT = 6'd24;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_MULT = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLL  = 3'b110;
  localparam logic [2:0] ALU_SRL  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode/funct decode: instruction class, ALU code and
// whether the destination register comes from the rd field.
module instr_decoder
  import proc_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic       o_is_legal,
  output logic       o_is_rtype,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic [2:0] o_alu_sel,
  output logic       o_dest_rd
);

  always_comb begin
    o_is_legal = 1'b0;
    o_is_rtype = 1'b0;
    o_is_load  = 1'b0;
    o_is_store = 1'b0;
    o_alu_sel  = ALU_ADD;
    o_dest_rd  = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_is_rtype = 1'b1;
        o_dest_rd  = 1'b1;
        o_is_legal = 1'b1;
        case (i_funct)
          FN_ADD:  o_alu_sel = ALU_ADD;
          FN_MULT: o_alu_sel = ALU_MULT;
          FN_AND:  o_alu_sel = ALU_AND;
          FN_OR:   o_alu_sel = ALU_OR;
          FN_XOR:  o_alu_sel = ALU_XOR;
          FN_NOR:  o_alu_sel = ALU_NOR;
          FN_SLL:  o_alu_sel = ALU_SLL;
          FN_SRL:  o_alu_sel = ALU_SRL;
          default: o_is_legal = 1'b0;
        endcase
      end
      OP_ADDI: o_is_legal = 1'b1;
      OP_LW: begin
        o_is_legal = 1'b1;
        o_is_load  = 1'b1;
      end
      OP_SW: begin
        o_is_legal = 1'b1;
        o_is_store = 1'b1;
      end
      default: o_is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing, IR, memory
// wait timeout, retired-instruction counter and sticky trap flags.
module multicycle_ctrl
  import proc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       wr_addr,
  output logic             reg_we,
  output logic [2:0]       alu_sel,
  output logic             alu_src_imm,
  output logic             wb_src,
  output logic             busy,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  // A request traps when the last permitted wait cycle also goes unanswered.
  localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [31:0]      r_ir;
  logic [CNT_W-1:0] r_retired;
  logic             r_illegal;
  logic             r_timeout;
  logic [7:0]       r_wait;

  logic       w_legal, w_rtype, w_load, w_store, w_dest_rd;
  logic [2:0] w_alu_sel;
  logic [4:0] w_wr_addr;
  logic       w_wait_last;
  logic       w_unused_ir;

  instr_decoder u_dec (
    .i_opcode   (r_ir[31:26]),
    .i_funct    (r_ir[5:0]),
    .o_is_legal (w_legal),
    .o_is_rtype (w_rtype),
    .o_is_load  (w_load),
    .o_is_store (w_store),
    .o_alu_sel  (w_alu_sel),
    .o_dest_rd  (w_dest_rd)
  );

  assign w_unused_ir = ^r_ir[10:6];
  assign w_wait_last = (r_wait == LP_WAIT_LAST);
  assign w_wr_addr   = w_dest_rd ? r_ir[15:11] : r_ir[20:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ir      <= 32'd0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_wait    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_wait  <= 8'd0;
          end
        end
        ST_FETCH: begin
          if (mem_ready) begin
            r_ir    <= instr;
            r_state <= ST_DECODE;
          end else if (w_wait_last) begin
            r_state   <= ST_TRAP;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_DECODE: begin
          if (w_legal) begin
            r_state <= ST_EXEC;
          end else begin
            r_state   <= ST_TRAP;
            r_illegal <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (w_load || w_store) begin
            r_state <= ST_MEM;
            r_wait  <= 8'd0;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM: begin
          // A store retires straight out of MEM; a load still needs WB.
          if (mem_ready) begin
            if (w_store) begin
              r_state   <= ST_FETCH;
              r_wait    <= 8'd0;
              r_retired <= r_retired + CNT_W'(1);
            end else begin
              r_state <= ST_WB;
            end
          end else if (w_wait_last) begin
            r_state   <= ST_TRAP;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_WB: begin
          r_state   <= ST_FETCH;
          r_wait    <= 8'd0;
          r_retired <= r_retired + CNT_W'(1);
        end
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    alu_sel     = 3'b000;
    alu_src_imm = 1'b0;
    wb_src      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      ST_EXEC: begin
        alu_sel     = w_alu_sel;
        alu_src_imm = ~w_rtype;
      end
      ST_MEM: begin
        mem_req     = 1'b1;
        mem_sel     = 1'b1;
        mem_we      = w_store;
        alu_sel     = w_alu_sel;
        alu_src_imm = ~w_rtype;
      end
      ST_WB: begin
        reg_we = (w_wr_addr != 5'd0);
        wb_src = w_load;
      end
      default: mem_req = 1'b0;
    endcase
  end

  assign rs_addr = r_ir[25:21];
  assign rt_addr = r_ir[20:16];
  assign wr_addr = w_wr_addr;
  assign busy    = (r_state != ST_IDLE) && (r_state != ST_TRAP);
  assign illegal = r_illegal;
  assign timeout = r_timeout;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scenario bench for multicycle_ctrl: per-cycle expected outputs from a small
// spec model are queued while driving and compared against sampled outputs.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP} ph_t;

  typedef struct packed {
    logic             mem_req;
    logic             mem_we;
    logic             mem_sel;
    logic             ir_we;
    logic             pc_we;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       wr;
    logic             reg_we;
    logic [2:0]       alu;
    logic             imm;
    logic             wb_src;
    logic             busy;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] retired;
  } obs_t;

  logic clk, reset, start, mem_ready;
  logic [31:0] instr;
  logic mem_req, mem_we, mem_sel, ir_we, pc_we, reg_we, alu_src_imm, wb_src;
  logic busy, illegal, timeout;
  logic [4:0] rs_addr, rt_addr, wr_addr;
  logic [2:0] alu_sel;
  logic [CNT_W-1:0] retired;
  obs_t w_obs;

  int checks = 0;
  int errors = 0;

  logic [31:0]      m_ir;
  logic [CNT_W-1:0] m_ret;
  logic             m_ill, m_to;
  obs_t exp_q[$];
  obs_t obs_q[$];

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .wr_addr(wr_addr), .reg_we(reg_we),
    .alu_sel(alu_sel), .alu_src_imm(alu_src_imm), .wb_src(wb_src), .busy(busy),
    .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  assign w_obs = {mem_req, mem_we, mem_sel, ir_we, pc_we, rs_addr, rt_addr, wr_addr,
                  reg_we, alu_sel, alu_src_imm, wb_src, busy, illegal, timeout, retired};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_alu(input logic [31:0] ir);
    if (ir[31:26] != 6'd0) return 3'd0;
    case (ir[5:0])
      6'd32:   return 3'd0;
      6'd24:   return 3'd1;
      6'd36:   return 3'd2;
      6'd37:   return 3'd3;
      6'd38:   return 3'd4;
      6'd39:   return 3'd5;
      6'd0:    return 3'd6;
      6'd2:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic obs_t model(input ph_t p, input logic rdy);
    obs_t o;
    logic [5:0] op;
    op = m_ir[31:26];
    o = '0;
    o.rs = m_ir[25:21];
    o.rt = m_ir[20:16];
    o.wr = (op == 6'd0) ? m_ir[15:11] : m_ir[20:16];
    o.busy = (p != P_IDLE) && (p != P_TRAP);
    o.illegal = m_ill;
    o.timeout = m_to;
    o.retired = m_ret;
    case (p)
      P_FETCH: begin o.mem_req = 1'b1; o.ir_we = rdy; o.pc_we = rdy; end
      P_EXEC:  begin o.alu = exp_alu(m_ir); o.imm = (op != 6'd0); end
      P_MEM: begin
        o.mem_req = 1'b1; o.mem_sel = 1'b1; o.mem_we = (op == 6'd43);
        o.alu = exp_alu(m_ir); o.imm = (op != 6'd0);
      end
      P_WB: begin o.reg_we = (o.wr != 5'd0); o.wb_src = (op == 6'd35); end
      default: o.mem_req = 1'b0;
    endcase
    return o;
  endfunction

  // One clock of stimulus in a known phase; expectation queued, output captured.
  task automatic drive_cycle(input ph_t p, input logic rdy, input logic st);
    start = st;
    mem_ready = rdy;
    exp_q.push_back(model(p, rdy));
    @(negedge clk);
    obs_q.push_back(w_obs);
    @(posedge clk); #1;
    if (p == P_FETCH && rdy) m_ir = instr;
    if (p == P_WB || (p == P_MEM && rdy && m_ir[31:26] == 6'd43)) m_ret = m_ret + CNT_W'(1);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait);
    instr = ins;
    repeat (fwait) drive_cycle(P_FETCH, 1'b0, 1'b0);
    drive_cycle(P_FETCH, 1'b1, 1'b0);
    drive_cycle(P_DECODE, 1'b1, 1'b0);
    drive_cycle(P_EXEC, 1'b1, 1'b0);
    if (ins[31:26] == 6'd35 || ins[31:26] == 6'd43) begin
      repeat (mwait) drive_cycle(P_MEM, 1'b0, 1'b0);
      drive_cycle(P_MEM, 1'b1, 1'b0);
    end
    if (ins[31:26] != 6'd43) drive_cycle(P_WB, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_ir = 32'd0; m_ret = '0; m_ill = 1'b0; m_to = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, o;
    do_reset();
    drive_cycle(P_IDLE, 1'b0, 1'b1);
    instr = 32'hACC40008;
    drive_cycle(P_FETCH, 1'b1, 1'b0);
    drive_cycle(P_DECODE, 1'b0, 1'b0);
    drive_cycle(P_EXEC, 1'b0, 1'b0);
    drive_cycle(P_MEM, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_pre_mem_req: got %b expected 1", mem_req); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (w_obs !== '0) begin errors++; $display("FAIL reset_outputs_%0d: got %h expected 0", k, w_obs); end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_ir = 32'd0; m_ret = '0; m_ill = 1'b0; m_to = 1'b0;
    drive_cycle(P_IDLE, 1'b1, 1'b0);
    drive_cycle(P_IDLE, 1'b0, 1'b1);
    drive_cycle(P_FETCH, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_add();
    obs_t e, o;
    do_reset();
    drive_cycle(P_IDLE, 1'b0, 1'b1);
    run_instr(32'h00221820, 0, 0);
    checks++;
    if (retired !== 4'd1) begin errors++; $display("FAIL add_retired: got %0d expected 1", retired); end
    drive_cycle(P_FETCH, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL add_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_addi_r0();
    obs_t e, o;
    do_reset();
    drive_cycle(P_IDLE, 1'b0, 1'b1);
    run_instr(32'h20A00007, 0, 0);
    drive_cycle(P_FETCH, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL addi_r0_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_sw_wait();
    obs_t e, o;
    do_reset();
    drive_cycle(P_IDLE, 1'b0, 1'b1);
    run_instr(32'hACC40008, 0, 3);
    drive_cycle(P_FETCH, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL sw_wait_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_lw_waits();
    obs_t e, o;
    do_reset();
    drive_cycle(P_IDLE, 1'b0, 1'b1);
    run_instr(32'h8C470004, 10, 14);
    run_instr(32'h00221820, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL lw_wait_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    logic [5:0] fn_tab [8];
    fn_tab = '{6'd32, 6'd24, 6'd36, 6'd37, 6'd38, 6'd39, 6'd0, 6'd2};
    do_reset();
    drive_cycle(P_IDLE, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++)
      run_instr({6'd0, 5'(i), 5'(i + 2), 5'(i + 1), 5'd0, fn_tab[i % 8]}, i % 2, 0);
    checks++;
    if (retired !== 4'd1) begin errors++; $display("FAIL wrap_retired: got %0d expected 1", retired); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back_seq: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_illegal();
    obs_t e, o;
    logic [31:0] bad [2];
    bad = '{32'hFC000000, 32'h00221803};
    for (int j = 0; j < 2; j++) begin
      do_reset();
      drive_cycle(P_IDLE, 1'b0, 1'b1);
      instr = bad[j];
      drive_cycle(P_FETCH, 1'b1, 1'b0);
      drive_cycle(P_DECODE, 1'b0, 1'b0);
      m_ill = 1'b1;
      drive_cycle(P_TRAP, 1'b0, 1'b1);
      drive_cycle(P_TRAP, 1'b1, 1'b1);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL illegal_%0d_seq: got %h expected %h", j, o, e); end
      end
    end
  endtask

  task automatic test_timeout();
    obs_t e, o;
    do_reset();
    drive_cycle(P_IDLE, 1'b0, 1'b1);
    instr = 32'h00221820;
    repeat (15) drive_cycle(P_FETCH, 1'b0, 1'b0);
    m_to = 1'b1;
    drive_cycle(P_TRAP, 1'b1, 1'b0);
    drive_cycle(P_TRAP, 1'b0, 1'b1);
    do_reset();
    drive_cycle(P_IDLE, 1'b0, 1'b1);
    run_instr(32'h00221820, 14, 0);
    drive_cycle(P_FETCH, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL timeout_seq: got %h expected %h", o, e); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; instr = 32'd0;
    m_ir = 32'd0; m_ret = '0; m_ill = 1'b0; m_to = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_addi_r0();
    test_sw_wait();
    test_lw_waits();
    test_back_to_back();
    test_illegal();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
